// File: rtl/i2c_master_mod.sv
// Byte-parallel I2C-style master: START, addr+R/W, ACK, one data byte, ACK, STOP.
// Transactions repeat back-to-back; every output is registered off the next state.
module i2c_master_mod (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_Slave_Add,
  input  logic       i_RW,
  input  logic [7:0] i_DATA,
  input  logic [7:0] i_SDA,
  input  logic       i_ACK,
  output logic [7:0] o_SDA,
  output logic       o_SCL,
  output logic [7:0] o_Add_RD
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR_L,
    S_ADDR_H,
    S_AACK_L,
    S_AACK_H,
    S_DATA_L,
    S_DATA_H,
    S_DACK_L,
    S_DACK_H,
    S_STOP_L,
    S_STOP_H
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [6:0] addr_q;
  logic       rw_q;
  logic [7:0] data_q;
  // Write-phase slave ACK is kept for debug only; it has no effect on the flow.
  logic       data_ack_unused;

  logic [7:0] sda_next;
  logic       scl_next;
  logic [7:0] add_rd_next;

  // Next-state logic: one clock per state, only the address ACK branches.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_next = state;
    case (state)
      S_IDLE:   state_next = S_START;
      S_START:  state_next = S_ADDR_L;
      S_ADDR_L: state_next = S_ADDR_H;
      S_ADDR_H: state_next = S_AACK_L;
      S_AACK_L: state_next = S_AACK_H;
      S_AACK_H: state_next = i_ACK ? S_DATA_L : S_STOP_L;
      S_DATA_L: state_next = S_DATA_H;
      S_DATA_H: state_next = S_DACK_L;
      S_DACK_L: state_next = S_DACK_H;
      S_DACK_H: state_next = S_STOP_L;
      S_STOP_L: state_next = S_STOP_H;
      S_STOP_H: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output values are decoded from the state being entered, so they appear
  // on the same edge that enters it.
  always_comb begin
    sda_next = 8'hFF;
    scl_next = 1'b1;
    case (state_next)
      S_START: sda_next = 8'h00;
      S_ADDR_L: begin
        sda_next = {addr_q, rw_q};
        scl_next = 1'b0;
      end
      S_ADDR_H: sda_next = {addr_q, rw_q};
      S_AACK_L: scl_next = 1'b0;
      S_DATA_L: begin
        sda_next = rw_q ? 8'hFF : data_q;
        scl_next = 1'b0;
      end
      S_DATA_H: sda_next = rw_q ? 8'hFF : data_q;
      S_DACK_L: scl_next = 1'b0;
      S_STOP_L: begin
        sda_next = 8'h00;
        scl_next = 1'b0;
      end
      S_STOP_H: sda_next = 8'h00;
      default: begin
        sda_next = 8'hFF;
        scl_next = 1'b1;
      end
    endcase
  end

  // o_Add_RD shows the address byte from ADDR_L on, replaced by the read byte
  // on the edge leaving DATA_H.
  always_comb begin
    add_rd_next = o_Add_RD;
    if (state_next == S_ADDR_L) begin
      add_rd_next = {addr_q, rw_q};
    end else if (state == S_DATA_H && rw_q) begin
      add_rd_next = i_SDA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      o_SDA    <= 8'hFF;
      o_SCL    <= 1'b1;
      o_Add_RD <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      state    <= state_next;
      o_SDA    <= sda_next;
      o_SCL    <= scl_next;
      o_Add_RD <= add_rd_next;
    end
  end

  // Transaction inputs are frozen on the edge entering START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= 7'h00;
      rw_q            <= 1'b0;
      data_q          <= 8'h00;
      data_ack_unused <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        addr_q <= i_Slave_Add;
        rw_q   <= i_RW;
        data_q <= i_DATA;
      end
      if (state == S_DACK_H && !rw_q) begin
        data_ack_unused <= i_ACK;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_mod.sv
// Self-checking bench for i2c_master_mod: per-cycle expected bus values are
// queued when a transaction is launched and compared as the DUT produces them.
module tb_i2c_master_mod;

  logic       clk;
  logic       rst_n;
  logic [6:0] i_Slave_Add;
  logic       i_RW;
  logic [7:0] i_DATA;
  logic [7:0] i_SDA;
  logic       i_ACK;
  logic [7:0] o_SDA;
  logic       o_SCL;
  logic [7:0] o_Add_RD;

  i2c_master_mod dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_Slave_Add(i_Slave_Add),
    .i_RW       (i_RW),
    .i_DATA     (i_DATA),
    .i_SDA      (i_SDA),
    .i_ACK      (i_ACK),
    .o_SDA      (o_SDA),
    .o_SCL      (o_SCL),
    .o_Add_RD   (o_Add_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sda;
    logic       scl;
    logic [7:0] add_rd;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_add_rd;
  int         n_checks;
  int         n_fail;
  int         txn_id;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] sda, input logic scl, input logic [7:0] add_rd);
    exp_t e;
    e.sda    = sda;
    e.scl    = scl;
    e.add_rd = add_rd;
    sb.push_back(e);
  endtask

  // Expected bus trace for one transaction, starting with the edge entering START.
  task automatic push_txn(input logic [6:0] addr, input logic rw, input logic [7:0] data,
                          input logic ack, input logic [7:0] rdata);
    logic [7:0] ab;
    logic [7:0] d;
    logic [7:0] post;
    ab   = {addr, rw};
    d    = rw ? 8'hFF : data;
    post = (rw && ack) ? rdata : ab;
    push(8'h00, 1'b1, exp_add_rd);
    push(ab,    1'b0, ab);
    push(ab,    1'b1, ab);
    push(8'hFF, 1'b0, ab);
    push(8'hFF, 1'b1, ab);
    if (ack) begin
      push(d,     1'b0, ab);
      push(d,     1'b1, ab);
      push(8'hFF, 1'b0, post);
      push(8'hFF, 1'b1, post);
    end
    push(8'h00, 1'b0, post);
    push(8'h00, 1'b1, post);
    push(8'hFF, 1'b1, post);
    exp_add_rd = post;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " sda"}, o_SDA, 8'hFF);
    check({tag, " scl"}, {7'b0, o_SCL}, 8'h01);
    check({tag, " add_rd"}, o_Add_RD, 8'h00);
  endtask

  // Called just after a negedge with the DUT idle or held in reset.
  task automatic run_txn(input logic [6:0] addr, input logic rw, input logic [7:0] data,
                         input logic ack, input logic [7:0] rdata,
                         input int change_at, input int abort_at);
    int   n;
    exp_t e;
    txn_id++;
    i_Slave_Add = addr;
    i_RW        = rw;
    i_DATA      = data;
    i_ACK       = ack;
    i_SDA       = rdata;
    push_txn(addr, rw, data, ack, rdata);
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("t%0d c%0d sda", txn_id, k), o_SDA, e.sda);
      check($sformatf("t%0d c%0d scl", txn_id, k), {7'b0, o_SCL}, {7'b0, e.scl});
      check($sformatf("t%0d c%0d add_rd", txn_id, k), o_Add_RD, e.add_rd);
      if (k == change_at) begin
        i_DATA      = 8'h55;
        i_Slave_Add = ~addr;
        i_RW        = ~rw;
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs($sformatf("t%0d abort", txn_id));
        sb.delete();
        exp_add_rd = 8'h00;
        break;
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    txn_id      = 0;
    exp_add_rd  = 8'h00;
    rst_n       = 1'b0;
    i_Slave_Add = 7'b1010101;
    i_RW        = 1'b0;
    i_DATA      = 8'h07;
    i_SDA       = 8'h00;
    i_ACK       = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Write AA/07 with ACK, then read returning 3C, then address NACK.
    run_txn(7'b1010101, 1'b0, 8'h07, 1'b1, 8'h00, -1, -1);
    run_txn(7'b1010101, 1'b1, 8'h07, 1'b1, 8'h3C, -1, -1);
    run_txn(7'b1010101, 1'b0, 8'h07, 1'b0, 8'h00, -1, -1);
    // Inputs changed at ADDR_H must not disturb the current transaction.
    run_txn(7'b1010101, 1'b0, 8'h07, 1'b1, 8'h00, 2, -1);
    run_txn(7'b1010101, 1'b0, 8'h55, 1'b1, 8'h00, -1, -1);
    // Abort at DATA_L, hold reset, then restart.
    run_txn(7'b1010101, 1'b0, 8'h07, 1'b1, 8'h00, -1, 5);
    repeat (2) @(negedge clk);
    check_reset_outputs("held");
    rst_n = 1'b1;
    run_txn(7'h12, 1'b1, 8'h99, 1'b1, 8'hA5, -1, -1);
    run_txn(7'h40, 1'b1, 8'h99, 1'b0, 8'h5A, -1, -1);
    run_txn(7'h6E, 1'b0, 8'hC3, 1'b1, 8'h00, -1, -1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
